// File: rtl/dcache_port_arb_pkg.sv
// Shared constants for the D$ port arbiter: requester indices, lane count
// from the core config, and the tag-width derivation used by arbiter and clients.
package dcache_port_arb_pkg;

  localparam int NUM_THREADS    = 4;
  localparam int DCACHE_REQ_LSU = 0;
  localparam int DCACHE_REQ_AUX = 1;
  localparam int DCACHE_ADDR_W  = 30;
  localparam int DCACHE_DATA_W  = 32;

  function automatic int req_sel_w(input int num_reqs);
    return (num_reqs > 1) ? $clog2(num_reqs) : 1;
  endfunction

  // Requester index rides in the tag LSBs on the way to the D$.
  function automatic int tag_out_w(input int tag_in_w, input int num_reqs);
    return tag_in_w + req_sel_w(num_reqs);
  endfunction

endpackage

// File: rtl/dcache_rr_pick.sv
// Combinational round-robin first-set finder: scans the pending mask upward
// from start with wrap and returns a one-hot grant plus its index.
module dcache_rr_pick #(
  parameter int N = 2,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] pending,
  input  logic [W-1:0] start,
  output logic [N-1:0] grant_oh,
  output logic [W-1:0] grant_idx,
  output logic         found
);

  int j;

  // Scan from farthest to nearest so the requester closest to start wins.
  always_comb begin
    grant_oh  = '0;
    grant_idx = '0;
    found     = 1'b0;
    j         = 0;
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(start) + i) % N;
      if (pending[j]) begin
        grant_oh    = '0;
        grant_oh[j] = 1'b1;
        grant_idx   = W'(j);
        found       = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dcache_port_arb.sv
// Shares one multi-lane D$ port among NUM_REQS requesters. Bundles are granted
// whole; a partially accepted bundle locks the port until its last lane fires.
module dcache_port_arb
  import dcache_port_arb_pkg::*;
#(
  parameter int NUM_REQS  = 2,
  parameter int NUM_LANES = NUM_THREADS,
  parameter int WORD_SIZE = 4,
  parameter int TAG_IN_W  = 16,
  parameter int REQ_SEL_W = req_sel_w(NUM_REQS),
  parameter int TAG_OUT_W = TAG_IN_W + REQ_SEL_W
) (
  input  logic                                                  clk,
  input  logic                                                  reset,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0]                    req_valid_in,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0]                    req_rw_in,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][DCACHE_ADDR_W-1:0] req_addr_in,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][WORD_SIZE-1:0]     req_byteen_in,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][DCACHE_DATA_W-1:0] req_data_in,
  input  logic [NUM_REQS-1:0][NUM_LANES-1:0][TAG_IN_W-1:0]      req_tag_in,
  output logic [NUM_REQS-1:0][NUM_LANES-1:0]                    req_ready_in,
  output logic [NUM_LANES-1:0]                                  req_valid_out,
  output logic [NUM_LANES-1:0]                                  req_rw_out,
  output logic [NUM_LANES-1:0][DCACHE_ADDR_W-1:0]               req_addr_out,
  output logic [NUM_LANES-1:0][WORD_SIZE-1:0]                   req_byteen_out,
  output logic [NUM_LANES-1:0][DCACHE_DATA_W-1:0]               req_data_out,
  output logic [NUM_LANES-1:0][TAG_OUT_W-1:0]                   req_tag_out,
  input  logic [NUM_LANES-1:0]                                  req_ready_out,
  input  logic                                                  rsp_valid_in,
  input  logic [NUM_LANES-1:0]                                  rsp_tmask_in,
  input  logic [NUM_LANES-1:0][DCACHE_DATA_W-1:0]               rsp_data_in,
  input  logic [TAG_OUT_W-1:0]                                  rsp_tag_in,
  output logic                                                  rsp_ready_in,
  output logic [NUM_REQS-1:0]                                   rsp_valid_out,
  output logic [NUM_LANES-1:0]                                  rsp_tmask_out,
  output logic [NUM_LANES-1:0][DCACHE_DATA_W-1:0]               rsp_data_out,
  output logic [TAG_IN_W-1:0]                                   rsp_tag_out,
  input  logic [NUM_REQS-1:0]                                   rsp_ready_out,
  output logic [NUM_REQS-1:0][31:0]                             stall_cnt,
  output logic                                                  idle
);

  logic                 locked;
  logic [REQ_SEL_W-1:0] owner, rr_ptr;
  logic [NUM_REQS-1:0]  pending, pick_oh, gnt;
  logic [REQ_SEL_W-1:0] pick_idx, g;
  logic                 pick_found, gvalid, complete;
  logic [NUM_LANES-1:0] g_lanes;
  logic [REQ_SEL_W-1:0] sel;

  always_comb begin
    pending = '0;
    for (int r = 0; r < NUM_REQS; r++) pending[r] = |req_valid_in[r];
  end

  dcache_rr_pick #(.N(NUM_REQS), .W(REQ_SEL_W)) u_pick (
    .pending   (pending),
    .start     (rr_ptr),
    .grant_oh  (pick_oh),
    .grant_idx (pick_idx),
    .found     (pick_found)
  );

  assign g      = locked ? owner : pick_idx;
  assign gvalid = locked | pick_found;

  always_comb begin
    gnt            = '0;
    g_lanes        = '0;
    req_ready_in   = '0;
    req_valid_out  = '0;
    req_rw_out     = '0;
    req_addr_out   = '0;
    req_byteen_out = '0;
    req_data_out   = '0;
    req_tag_out    = '0;
    for (int r = 0; r < NUM_REQS; r++) begin
      gnt[r] = locked ? (owner == REQ_SEL_W'(r)) : pick_oh[r];
      if (gnt[r]) begin
        g_lanes         = req_valid_in[r];
        req_ready_in[r] = req_ready_out;
        req_valid_out   = req_valid_in[r];
        req_rw_out      = req_rw_in[r];
        req_addr_out    = req_addr_in[r];
        req_byteen_out  = req_byteen_in[r];
        req_data_out    = req_data_in[r];
        for (int l = 0; l < NUM_LANES; l++)
          req_tag_out[l] = {req_tag_in[r][l], REQ_SEL_W'(r)};
      end
    end
  end

  // Lanes not valid this cycle count as done: they fired in an earlier cycle.
  assign complete = gvalid && (&(req_ready_out | ~g_lanes));

  always_ff @(posedge clk) begin
    if (reset) begin
      locked <= 1'b0;
      owner  <= '0;
      rr_ptr <= '0;
    end else if (complete) begin
      locked <= 1'b0;
      rr_ptr <= (int'(g) == NUM_REQS - 1) ? '0 : g + 1'b1;
    end else if (gvalid) begin
      locked <= 1'b1;
      owner  <= g;
    end
  end

  for (genvar r = 0; r < NUM_REQS; r++) begin : g_cnt
    logic [31:0] cnt;
    always_ff @(posedge clk) begin
      if (reset)                   cnt <= '0;
      else if (pending[r] && !gnt[r]) cnt <= cnt + 32'd1;
    end
    assign stall_cnt[r] = cnt;
  end

  assign sel = rsp_tag_in[REQ_SEL_W-1:0];

  always_comb begin
    rsp_valid_out = '0;
    rsp_ready_in  = 1'b0;
    for (int r = 0; r < NUM_REQS; r++) begin
      if (sel == REQ_SEL_W'(r)) begin
        rsp_valid_out[r] = rsp_valid_in;
        rsp_ready_in     = rsp_ready_out[r];
      end
    end
  end

  assign rsp_tag_out   = rsp_tag_in[TAG_OUT_W-1:REQ_SEL_W];
  assign rsp_tmask_out = rsp_tmask_in;
  assign rsp_data_out  = rsp_data_in;
  assign idle          = ~locked;

endmodule
